// File: rtl/wave_capture.sv
// Triggered sample capture sink: decimates the stream with a phase-step tick, captures
// SAMP_DEPTH samples after an armed trigger, tracks signed peaks and exposes a read port.
module wave_capture #(
    parameter int unsigned SAMP_WIDTH = 24,
    parameter int unsigned SAMP_DEPTH = 1024,
    localparam int unsigned SAMP_ADDR = $clog2(SAMP_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [SAMP_WIDTH-1:0] i_sample,
    input  logic [15:0]           i_phase_step,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic [1:0]            i_trig_mode,
    input  logic [SAMP_WIDTH-1:0] i_trig_level,
    input  logic                  i_rd_en,
    input  logic [SAMP_ADDR-1:0]  i_rd_addr,
    output logic [SAMP_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SAMP_ADDR:0]    o_count,
    output logic [SAMP_WIDTH-1:0] o_peak_max,
    output logic [SAMP_WIDTH-1:0] o_peak_min
);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    localparam logic [SAMP_ADDR-1:0] LastAddr = SAMP_ADDR'(SAMP_DEPTH - 1);
    localparam logic [SAMP_ADDR-1:0] AddrOne  = SAMP_ADDR'(1);
    localparam logic [SAMP_ADDR:0]   CntOne   = (SAMP_ADDR + 1)'(1);

    state_e                  state_q, state_d;
    logic [15:0]             p_count_q;
    logic [SAMP_WIDTH-1:0]   prev_sample_q;
    logic                    prev_valid_q;
    logic [SAMP_ADDR-1:0]    wr_addr_q;
    logic [SAMP_ADDR:0]      count_q;
    logic [SAMP_WIDTH-1:0]   peak_max_q, peak_min_q;
    logic [SAMP_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q, busy_q, done_q;
    logic [SAMP_WIDTH-1:0]   mem [SAMP_DEPTH];

    logic tick, trig_hit, rise, fall, arm_clr, do_write, first_write;

    // Compare with >= so lowering the step below p_count ticks at once instead of wrapping.
    assign tick = (p_count_q >= i_phase_step);

    assign rise = prev_valid_q && ($signed(prev_sample_q) < $signed(i_trig_level))
               && ($signed(i_sample) >= $signed(i_trig_level));
    assign fall = prev_valid_q && ($signed(prev_sample_q) > $signed(i_trig_level))
               && ($signed(i_sample) <= $signed(i_trig_level));

    always_comb begin
        case (i_trig_mode)
            2'b01:   trig_hit = rise;
            2'b10:   trig_hit = fall;
            default: trig_hit = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        arm_clr     = 1'b0;
        do_write    = 1'b0;
        first_write = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (i_arm && !i_abort) begin
                    state_d = StArmed;
                    arm_clr = 1'b1;
                end
            end
            StArmed: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (tick && trig_hit) begin
                    do_write    = 1'b1;
                    first_write = 1'b1;
                    state_d     = (wr_addr_q == LastAddr) ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (i_abort) begin
                    state_d = StIdle;
                end else if (tick) begin
                    do_write = 1'b1;
                    if (wr_addr_q == LastAddr) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            p_count_q     <= '0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            wr_addr_q     <= '0;
            count_q       <= '0;
            peak_max_q    <= '0;
            peak_min_q    <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_count_q  <= tick ? 16'd0 : p_count_q + 16'd1;
            busy_q     <= (state_d == StArmed) || (state_d == StCapture);
            done_q     <= (state_d == StDone);
            rd_valid_q <= i_rd_en;
            if (i_rd_en) rd_data_q <= mem[i_rd_addr];
            if (tick) prev_sample_q <= i_sample;

            if (arm_clr) begin
                prev_valid_q <= 1'b0;
            end else if (state_q == StArmed && tick) begin
                prev_valid_q <= 1'b1;
            end

            if (arm_clr) begin
                wr_addr_q  <= '0;
                count_q    <= '0;
                peak_max_q <= '0;
                peak_min_q <= '0;
            end else if (do_write) begin
                wr_addr_q <= wr_addr_q + AddrOne;
                count_q   <= count_q + CntOne;
                if (first_write || $signed(i_sample) > $signed(peak_max_q)) peak_max_q <= i_sample;
                if (first_write || $signed(i_sample) < $signed(peak_min_q)) peak_min_q <= i_sample;
            end
        end
    end

    // Capture RAM is not reset; the read above sees the pre-write word on a collision.
    always_ff @(posedge i_clk) begin
        if (do_write) mem[wr_addr_q] <= i_sample;
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_count    = count_q;
    assign o_peak_max = peak_max_q;
    assign o_peak_min = peak_min_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: read-back tables plus hand-written trigger, abort,
// collision and tick-divider sequences.
module tb_wave_capture;
    localparam int W = 24;
    localparam int D = 1024;
    localparam int A = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   sample = '0;
    logic [15:0]    step = '0;
    logic           arm = 1'b0;
    logic           abort = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [W-1:0]   level = '0;
    logic           rd_en = 1'b0;
    logic [A-1:0]   rd_addr = '0;
    logic [W-1:0]   rd_data;
    logic           rd_valid, busy, done;
    logic [A:0]     count;
    logic [W-1:0]   pmax, pmin;

    int  total = 0;
    int  bad = 0;
    bit  ramp_en = 1'b0;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } rd_vec_t;

    rd_vec_t ramp_tab [8];
    rd_vec_t step_tab [4];

    always #5 clk = ~clk;

    wave_capture #(.SAMP_WIDTH(W), .SAMP_DEPTH(D)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sample     (sample),
        .i_phase_step (step),
        .i_arm        (arm),
        .i_abort      (abort),
        .i_trig_mode  (mode),
        .i_trig_level (level),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_busy       (busy),
        .o_done       (done),
        .o_count      (count),
        .o_peak_max   (pmax),
        .o_peak_min   (pmin)
    );

    function automatic logic [W-1:0] s24(input int v);
        return v[W-1:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (ramp_en) sample = sample + 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic rd_check(input string name, input logic [A-1:0] a, input logic [W-1:0] e);
        rd_en = 1'b1;
        rd_addr = a;
        cyc();
        rd_en = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_data"}, 32'(rd_data), 32'(e));
        cyc();
        chk({name, "_novalid"}, 32'(rd_valid), 32'd0);
        chk({name, "_hold"}, 32'(rd_data), 32'(e));
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_cnt_change(input int bound, output int n);
        logic [A:0] c0;
        c0 = count;
        n = 0;
        while (count == c0 && n < bound) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [W-1:0] trig_val;
        logic [W-1:0] diff;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_max", 32'(pmax), 0);
        chk("rst_rdvalid", 32'(rd_valid), 0);
        rst_n = 1'b1;
        cyc();

        // Reset in the middle of a capture
        sample = s24(42);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("t1_busy_rise", 32'(busy), 1);
        cyc(); cyc(); cyc(); cyc();
        rd_en = 1'b1;
        rd_addr = '0;
        cyc();
        rd_en = 1'b0;
        chk("t1_count5", 32'(count), 5);
        chk("t1_rd42", 32'(rd_data), 42);
        chk("t1_max42", 32'(pmax), 42);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_count", 32'(count), 0);
        chk("t1_rst_max", 32'(pmax), 0);
        chk("t1_rst_min", 32'(pmin), 0);
        chk("t1_rst_rddata", 32'(rd_data), 0);
        chk("t1_rst_rdvalid", 32'(rd_valid), 0);
        #2 rst_n = 1'b1;
        cyc();
        chk("t1_idle_after_rst", 32'(busy), 0);

        // Immediate trigger on a per-clock ramp
        sample = '0;
        step = 16'd0;
        mode = 2'b00;
        ramp_en = 1'b1;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        trig_val = sample;
        chk("t2_busy", 32'(busy), 1);
        wait_done(1100, n);
        ramp_en = 1'b0;
        chk("t2_done", 32'(done), 1);
        chk("t2_latency", 32'(n), 1024);
        chk("t2_busy_low", 32'(busy), 0);
        chk("t2_count", 32'(count), 1024);
        diff = pmax - pmin;
        chk("t2_span", 32'(diff), 1023);
        chk("t2_min", 32'(pmin), 32'(trig_val));
        ramp_tab[0] = '{addr: 10'd0,    data: trig_val};
        ramp_tab[1] = '{addr: 10'd1,    data: trig_val + 24'd1};
        ramp_tab[2] = '{addr: 10'd2,    data: trig_val + 24'd2};
        ramp_tab[3] = '{addr: 10'd5,    data: trig_val + 24'd5};
        ramp_tab[4] = '{addr: 10'd511,  data: trig_val + 24'd511};
        ramp_tab[5] = '{addr: 10'd512,  data: trig_val + 24'd512};
        ramp_tab[6] = '{addr: 10'd1022, data: trig_val + 24'd1022};
        ramp_tab[7] = '{addr: 10'd1023, data: trig_val + 24'd1023};
        for (int i = 0; i < 8; i++) rd_check($sformatf("t2_rd%0d", i), ramp_tab[i].addr,
                                             ramp_tab[i].data);

        // Rising crossing with a 4-clock sample period, re-armed from DONE
        step = 16'd3;
        mode = 2'b01;
        level = s24(100);
        sample = s24(-50);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("t3_done_clr", 32'(done), 0);
        chk("t3_count_clr", 32'(count), 0);
        chk("t3_peak_clr", 32'(pmax), 0);
        for (int i = 0; i < 12; i++) cyc();
        chk("t3_no_trig", 32'(count), 0);
        sample = s24(150);
        for (int i = 0; i < 4; i++) cyc();
        sample = s24(300);
        chk("t3_trig", 32'(count), 1);
        wait_cnt_change(10, n);
        wait_cnt_change(10, n);
        chk("t3_period_a", 32'(n), 4);
        wait_cnt_change(10, n);
        chk("t3_period_b", 32'(n), 4);
        wait_done(5000, n);
        chk("t3_done", 32'(done), 1);
        chk("t3_min", 32'(pmin), 32'(s24(150)));
        chk("t3_max", 32'(pmax), 32'(s24(300)));
        step_tab[0] = '{addr: 10'd0,    data: s24(150)};
        step_tab[1] = '{addr: 10'd1,    data: s24(300)};
        step_tab[2] = '{addr: 10'd512,  data: s24(300)};
        step_tab[3] = '{addr: 10'd1023, data: s24(300)};
        for (int i = 0; i < 4; i++) rd_check($sformatf("t3_rd%0d", i), step_tab[i].addr,
                                             step_tab[i].data);

        // Falling crossing; first tick after arm must not trigger
        step = 16'd0;
        mode = 2'b10;
        level = '0;
        sample = s24(5);
        cyc(); cyc();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        sample = s24(-5);
        cyc();
        chk("t4_first_tick", 32'(count), 0);
        cyc(); cyc(); cyc();
        chk("t4_below_hold", 32'(count), 0);
        chk("t4_busy", 32'(busy), 1);
        sample = s24(7);
        cyc();
        chk("t4_positive", 32'(count), 0);
        sample = '0;
        cyc();
        chk("t4_trig", 32'(count), 1);
        for (int k = 1; k <= 9; k++) begin
            sample = s24(-k);
            cyc();
        end
        chk("t5_count10", 32'(count), 10);

        // Abort keeps partial count and peaks
        abort = 1'b1;
        sample = s24(-100);
        cyc();
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_count", 32'(count), 10);
        chk("t5_max", 32'(pmax), 0);
        chk("t5_min", 32'(pmin), 32'(s24(-9)));
        rd_check("t5_rd9", 10'd9, s24(-9));
        arm = 1'b1;
        abort = 1'b1;
        cyc();
        arm = 1'b0;
        abort = 1'b0;
        chk("t5_arm_abort_busy", 32'(busy), 0);
        chk("t5_arm_abort_count", 32'(count), 10);

        // Re-arm, then a read colliding with the write to address 5
        mode = 2'b00;
        sample = s24(999);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("t5_rearm_count", 32'(count), 0);
        chk("t5_rearm_min", 32'(pmin), 0);
        for (int j = 1; j <= 6; j++) begin
            sample = s24(1000 + j - 1);
            if (j == 6) begin
                rd_en = 1'b1;
                rd_addr = 10'd5;
            end
            cyc();
        end
        rd_en = 1'b0;
        chk("t6_coll_valid", 32'(rd_valid), 1);
        chk("t6_coll_old", 32'(rd_data), 32'(s24(-5)));
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t6_count6", 32'(count), 6);
        rd_check("t6_rd5_new", 10'd5, s24(1005));

        // Phase step lowered below the running count
        step = 16'd1000;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        wait_cnt_change(1100, n);
        chk("t6_first_tick", 32'(count), 1);
        for (int i = 0; i < 500; i++) cyc();
        chk("t6_no_tick_500", 32'(count), 1);
        step = 16'd2;
        cyc();
        chk("t6_tick_now", 32'(count), 2);
        cyc();
        chk("t6_gap1", 32'(count), 2);
        cyc();
        chk("t6_gap2", 32'(count), 2);
        cyc();
        chk("t6_tick3", 32'(count), 3);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Sample sink at the output end of the FIR low-pass chain. It is the capture counterpart of the noise/sine stimulus source.
- Decimates the incoming sample stream with the same phase-step tick scheme the source uses.
- Waits for an armed trigger, then writes SAMP_DEPTH consecutive samples into an internal RAM and tracks signed min/max.
- Captured data is read back through a registered read port for host/debug readout.

Parameters:
SAMP_WIDTH, 24, sample width in bits (two's complement)
SAMP_DEPTH, 1024, capture buffer depth; power of two; SAMP_ADDR = $clog2(SAMP_DEPTH)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_sample  in  SAMP_WIDTH  signed sample stream (FIR output), sampled on tick
i_phase_step  in  16  tick divider terminal count; sample period = i_phase_step+1 clocks
i_arm  in  1  one-cycle arm request
i_abort  in  1  one-cycle abort request
i_trig_mode  in  2  00 immediate, 01 rising crossing, 10 falling crossing, 11 reserved (treated as 00)
i_trig_level  in  SAMP_WIDTH  signed trigger threshold
i_rd_en  in  1  read strobe
i_rd_addr  in  SAMP_ADDR  read address
o_rd_data  out  SAMP_WIDTH  read data
o_rd_valid  out  1  read data valid
o_busy  out  1  high in ARMED or CAPTURE
o_done  out  1  high in DONE
o_count  out  SAMP_ADDR+1  samples written in current/last capture
o_peak_max  out  SAMP_WIDTH  signed max of captured samples
o_peak_min  out  SAMP_WIDTH  signed min of captured samples

Behaviour:
- Reset (async, i_rst_n=0) sets:
  - FSM to IDLE; tick counter, write address, o_count and prev-sample register to 0.
  - o_peak_max, o_peak_min, o_rd_data, o_rd_valid, o_busy and o_done to 0.
  - RAM contents are not reset.
- Tick divider: free-running 16-bit p_count.
  - tick = (p_count >= i_phase_step). On tick, p_count <= 0; otherwise p_count + 1.
  - i_phase_step=0 gives a tick every clock.
  - Lowering i_phase_step below p_count produces a tick on the next clock, never a 16-bit wrap.
- prev_sample <= i_sample on every tick, in all states. prev_valid is cleared on arm and set on the first tick in ARMED.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED on i_arm. Entering ARMED clears o_count, o_done, o_peak_max and o_peak_min.
  - DONE -> ARMED on i_arm, with the same clears.
  - i_arm is ignored in ARMED and CAPTURE.
  - ARMED -> CAPTURE on a tick when the trigger condition holds; the triggering tick's sample is written to address 0.
  - Trigger conditions (signed compare):
    - immediate: any tick.
    - rising: prev_valid && prev_sample < i_trig_level && i_sample >= i_trig_level.
    - falling: prev_valid && prev_sample > i_trig_level && i_sample <= i_trig_level.
  - The first tick after arming can only trigger in immediate mode.
  - CAPTURE: on each tick, mem[wr_addr] <= i_sample, wr_addr++, o_count++.
  - CAPTURE -> DONE on the tick that writes address SAMP_DEPTH-1. o_count then reads SAMP_DEPTH; wr_addr wraps to 0.
  - i_abort in ARMED or CAPTURE -> IDLE. o_count and the peaks keep their partial values; o_done stays 0.
  - i_abort has priority over a same-cycle trigger or write. i_abort in IDLE or DONE has no effect.
  - i_arm and i_abort in the same cycle: abort wins.
- Peaks:
  - On the triggering sample, max = min = sample.
  - On each later captured sample, max = larger(max, s) and min = smaller(min, s), signed.
  - Peak outputs and o_count are registered and update the cycle after the write.
- Read port:
  - i_rd_en at cycle N gives o_rd_data = mem[i_rd_addr] and o_rd_valid = 1 at cycle N+1.
  - o_rd_valid is 0 when there is no strobe; o_rd_data holds its last value.
  - Reads are allowed in any state.
  - A same-cycle read and write to the same address returns the old data (read-first).
- o_busy and o_done are registered decodes of the state. The FSM leaves IDLE on the clock edge that samples i_arm, so o_busy rises one cycle after i_arm.

Test Plan:
1. Reset during CAPTURE (i_rst_n low mid-capture) -> all outputs 0, state IDLE, o_busy=0; a subsequent arm works normally.
2. i_phase_step=0, mode 00, i_sample = ramp 0,1,2… incrementing each clock, pulse i_arm -> o_done after 1024 ticks. Reading addr k returns the trigger value + k, with o_rd_valid one cycle after i_rd_en. o_count=1024 and o_peak_max - o_peak_min = 1023.
3. i_phase_step=3, mode 01, level=100, i_sample steps -50 -> 150 -> 300 held per tick -> capture starts on the 150 sample. mem[0]=150, ticks arrive every 4 clocks, o_peak_min=150.
4. Mode 10, level=0, input already ≤0 at arm time -> no trigger until a positive-to-≤0 crossing. A first tick at -5 right after arm does not trigger (prev_valid=0).
5. Abort after 10 captured samples -> state IDLE, o_done=0, o_count=10. Re-arm clears o_count and the peaks to 0.
6. Read addr 5 in the same cycle CAPTURE writes addr 5 -> old RAM value returned. Change i_phase_step from 1000 to 2 while p_count=500 -> tick on the next clock, then a tick every 3 clocks.
